// File: rtl/note_sequencer_mc.sv
// note_sequencer_mc: CHANNELS independent pattern walkers sharing one synchronous
// pattern-ROM port through a round-robin arbiter. Fetch pipeline: grant -> ROM -> capture.
// Build option: define NOTE_SEQ_OVERRUN_EN to synthesise the sticky per-channel
// strobe-overrun flags; otherwise o_overrun is tied low.
module note_sequencer_mc #(
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 16,
    localparam int unsigned CH_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [CHANNELS-1:0]            i_note_stb,
    input  logic [ADDR_WIDTH-1:0]          i_new_addr,
    input  logic [ADDR_WIDTH-1:0]          i_new_pattern_len,
    input  logic                           i_new_loop,
    input  logic [CH_WIDTH-1:0]            i_new_ch,
    input  logic                           i_new_addr_valid,
    output logic [ADDR_WIDTH-1:0]          o_rom_addr,
    input  logic [DATA_WIDTH-1:0]          i_rom_data,
    output logic [CHANNELS*DATA_WIDTH-1:0] o_note_data,
    output logic [CHANNELS-1:0]            o_new_note_valid,
    output logic [CHANNELS-1:0]            o_done,
    output logic [CHANNELS-1:0]            o_overrun
);

    // Per-channel pattern state
    logic [ADDR_WIDTH-1:0] base_q [CHANNELS];
    logic [ADDR_WIDTH-1:0] base_d [CHANNELS];
    logic [ADDR_WIDTH-1:0] len_q  [CHANNELS];
    logic [ADDR_WIDTH-1:0] len_d  [CHANNELS];
    logic [ADDR_WIDTH-1:0] idx_q  [CHANNELS];
    logic [ADDR_WIDTH-1:0] idx_d  [CHANNELS];
    logic [CHANNELS-1:0]   loop_q, loop_d;
    logic [CHANNELS-1:0]   pend_q, pend_d;
    logic [CHANNELS-1:0]   exh_q, exh_d;    // last one-shot entry already issued
    logic [CHANNELS-1:0]   done_q, done_d;

    // Arbiter and fetch pipeline
    logic [CH_WIDTH-1:0]   last_gnt_q, last_gnt_d;
    logic                  s1_vld_q, s1_vld_d;
    logic [CH_WIDTH-1:0]   s1_ch_q, s1_ch_d;
    logic                  s1_last_q, s1_last_d;
    logic                  s2_vld_q, s2_vld_d;
    logic [CH_WIDTH-1:0]   s2_ch_q, s2_ch_d;
    logic                  s2_last_q, s2_last_d;

    // Registered outputs
    logic [ADDR_WIDTH-1:0]          rom_addr_q, rom_addr_d;
    logic [CHANNELS*DATA_WIDTH-1:0] note_data_q, note_data_d;
    logic [CHANNELS-1:0]            valid_q, valid_d;

    // Combinational decode
    logic [CHANNELS-1:0] load_c, req_c, s1_hit_c, s2_hit_c, is_last_c;
    logic                gnt_vld_c;
    logic [CH_WIDTH-1:0] gnt_ch_c;

`ifdef NOTE_SEQ_OVERRUN_EN
    logic [CHANNELS-1:0] ovr_q, ovr_d;
    assign o_overrun = ovr_q;
`else
    assign o_overrun = '0;
`endif

    assign o_rom_addr       = rom_addr_q;
    assign o_note_data      = note_data_q;
    assign o_new_note_valid = valid_q;
    assign o_done           = done_q;

    // Decode load target, in-flight ownership and end-of-pattern per channel
    always_comb begin
        load_c    = '0;
        s1_hit_c  = '0;
        s2_hit_c  = '0;
        is_last_c = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            load_c[c]    = i_new_addr_valid && (i_new_ch == CH_WIDTH'(c));
            s1_hit_c[c]  = s1_vld_q && (s1_ch_q == CH_WIDTH'(c));
            s2_hit_c[c]  = s2_vld_q && (s2_ch_q == CH_WIDTH'(c));
            is_last_c[c] = (({1'b0, idx_q[c]} + (ADDR_WIDTH+1)'(1)) == {1'b0, len_q[c]});
        end
        // A channel being reloaded this cycle must not be granted its stale request
        req_c = pend_q & ~load_c;
    end

    // Round-robin arbiter: first requester after the last granted channel
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_ch_c  = '0;
        for (int off = 1; off <= int'(CHANNELS); off++) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (!gnt_vld_c && req_c[c] &&
                    (c == ((int'(last_gnt_q) + off) % int'(CHANNELS)))) begin
                    gnt_vld_c = 1'b1;
                    gnt_ch_c  = CH_WIDTH'(c);
                end
            end
        end
    end

    // Next-state: grant/advance, capture, load (overrides), then strobe
    always_comb begin
        base_d      = base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        loop_d      = loop_q;
        pend_d      = pend_q;
        exh_d       = exh_q;
        done_d      = done_q;
        rom_addr_d  = rom_addr_q;
        note_data_d = note_data_q;
        valid_d     = '0;
        last_gnt_d  = gnt_vld_c ? gnt_ch_c : last_gnt_q;
        s1_vld_d    = gnt_vld_c;
        s1_ch_d     = gnt_ch_c;
        s1_last_d   = 1'b0;
        s2_vld_d    = |(s1_hit_c & ~load_c);
        s2_ch_d     = s1_ch_q;
        s2_last_d   = s1_last_q;
`ifdef NOTE_SEQ_OVERRUN_EN
        ovr_d       = ovr_q;
`endif
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (gnt_vld_c && (gnt_ch_c == CH_WIDTH'(c))) begin
                pend_d[c]  = 1'b0;
                rom_addr_d = ADDR_WIDTH'(base_q[c] + idx_q[c]);
                if (is_last_c[c]) begin
                    if (loop_q[c]) begin
                        idx_d[c] = '0;
                    end else begin
                        exh_d[c]  = 1'b1;
                        s1_last_d = 1'b1;
                    end
                end else begin
                    idx_d[c] = idx_q[c] + ADDR_WIDTH'(1);
                end
            end

            if (s2_hit_c[c] && !load_c[c]) begin
                note_data_d[c*DATA_WIDTH +: DATA_WIDTH] = i_rom_data;
                valid_d[c] = 1'b1;
                if (s2_last_q) begin
                    done_d[c] = 1'b1;
                end
            end

            if (load_c[c]) begin
                base_d[c] = i_new_addr;
                len_d[c]  = i_new_pattern_len;
                loop_d[c] = i_new_loop;
                idx_d[c]  = '0;
                pend_d[c] = 1'b0;
                exh_d[c]  = 1'b0;
                done_d[c] = 1'b0;
`ifdef NOTE_SEQ_OVERRUN_EN
                ovr_d[c]  = 1'b0;
`endif
                if (i_note_stb[c] && (i_new_pattern_len != '0)) begin
                    pend_d[c] = 1'b1;
                end
            end else if (i_note_stb[c] && (len_q[c] != '0) && !done_q[c] && !exh_q[c]) begin
                // A strobe while still pending merges into the outstanding request
                if (!pend_q[c]) begin
                    pend_d[c] = 1'b1;
                end
`ifdef NOTE_SEQ_OVERRUN_EN
                if (pend_q[c] || s1_hit_c[c] || s2_hit_c[c]) begin
                    ovr_d[c] = 1'b1;
                end
`endif
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                base_q[c] <= '0;
                len_q[c]  <= '0;
                idx_q[c]  <= '0;
            end
            loop_q      <= '0;
            pend_q      <= '0;
            exh_q       <= '0;
            done_q      <= '0;
            last_gnt_q  <= CH_WIDTH'(CHANNELS - 1);
            s1_vld_q    <= 1'b0;
            s1_ch_q     <= '0;
            s1_last_q   <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_ch_q     <= '0;
            s2_last_q   <= 1'b0;
            rom_addr_q  <= '0;
            note_data_q <= '0;
            valid_q     <= '0;
`ifdef NOTE_SEQ_OVERRUN_EN
            ovr_q       <= '0;
`endif
        end else begin
            base_q      <= base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            loop_q      <= loop_d;
            pend_q      <= pend_d;
            exh_q       <= exh_d;
            done_q      <= done_d;
            last_gnt_q  <= last_gnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_ch_q     <= s1_ch_d;
            s1_last_q   <= s1_last_d;
            s2_vld_q    <= s2_vld_d;
            s2_ch_q     <= s2_ch_d;
            s2_last_q   <= s2_last_d;
            rom_addr_q  <= rom_addr_d;
            note_data_q <= note_data_d;
            valid_q     <= valid_d;
`ifdef NOTE_SEQ_OVERRUN_EN
            ovr_q       <= ovr_d;
`endif
        end
    end

endmodule

// File: tb/tb_note_sequencer_mc.sv
// Bench for note_sequencer_mc: directed vector tables, hand-written corner sequences,
// and a randomized run checked against a per-channel expected-fetch model.
`timescale 1ns/1ps
module tb_note_sequencer_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  stb;
    logic [4:0]  new_addr;
    logic [4:0]  new_len;
    logic        new_loop;
    logic [1:0]  new_ch;
    logic        new_vld;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic [47:0] note_data;
    logic [2:0]  nvalid;
    logic [2:0]  done;
    logic [2:0]  ovr;

    logic [15:0] rom [32];
    int n_tests = 0;
    int n_fail  = 0;
    int vcnt [3];

`ifdef NOTE_SEQ_OVERRUN_EN
    localparam logic [2:0] EXP_OVR = 3'b100;
`else
    localparam logic [2:0] EXP_OVR = 3'b000;
`endif

    note_sequencer_mc #(.CHANNELS(3), .ADDR_WIDTH(5), .DATA_WIDTH(16)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_note_stb        (stb),
        .i_new_addr        (new_addr),
        .i_new_pattern_len (new_len),
        .i_new_loop        (new_loop),
        .i_new_ch          (new_ch),
        .i_new_addr_valid  (new_vld),
        .o_rom_addr        (rom_addr),
        .i_rom_data        (rom_data),
        .o_note_data       (note_data),
        .o_new_note_valid  (nvalid),
        .o_done            (done),
        .o_overrun         (ovr)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after address
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic [2:0]  stb;
        logic        ld;
        logic [1:0]  ld_ch;
        logic [4:0]  ld_addr;
        logic [4:0]  ld_len;
        logic        ld_loop;
        logic [2:0]  exp_valid;
        logic [2:0]  exp_done;
        logic        chk_addr;
        logic [4:0]  exp_addr;
        logic        chk_data;
        logic [1:0]  data_ch;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl [32];
    int   n_vec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int c = 0; c < 3; c++) if (nvalid[c]) vcnt[c]++;
        stb     = '0;
        new_vld = 1'b0;
    endtask

    task automatic clr_vcnt();
        for (int c = 0; c < 3; c++) vcnt[c] = 0;
    endtask

    task automatic load(input logic [1:0] ch, input logic [4:0] a, input logic [4:0] len,
                        input logic lp);
        new_ch = ch; new_addr = a; new_len = len; new_loop = lp; new_vld = 1'b1;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stb = '0; new_vld = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clr_vcnt();
    endtask

    task automatic clr_tbl(input int n);
        n_vec = n;
        for (int i = 0; i < 32; i++) tbl[i] = '{default: '0};
    endtask

    task automatic set_ld(input int i, input logic [1:0] ch, input logic [4:0] a,
                          input logic [4:0] len, input logic lp);
        tbl[i].ld = 1'b1; tbl[i].ld_ch = ch; tbl[i].ld_addr = a;
        tbl[i].ld_len = len; tbl[i].ld_loop = lp;
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        tbl[i].chk_addr = 1'b1; tbl[i].exp_addr = a;
    endtask

    task automatic set_val(input int i, input logic [1:0] ch, input logic [15:0] d);
        tbl[i].exp_valid[ch] = 1'b1; tbl[i].chk_data = 1'b1;
        tbl[i].data_ch = ch; tbl[i].exp_data = d;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < n_vec; i++) begin
            stb = tbl[i].stb;
            if (tbl[i].ld) begin
                new_vld = 1'b1; new_ch = tbl[i].ld_ch; new_addr = tbl[i].ld_addr;
                new_len = tbl[i].ld_len; new_loop = tbl[i].ld_loop;
            end
            step();
            chk($sformatf("%s[%0d] valid", tag, i), 64'(nvalid), 64'(tbl[i].exp_valid));
            chk($sformatf("%s[%0d] done", tag, i), 64'(done), 64'(tbl[i].exp_done));
            if (tbl[i].chk_addr)
                chk($sformatf("%s[%0d] rom_addr", tag, i), 64'(rom_addr), 64'(tbl[i].exp_addr));
            if (tbl[i].chk_data)
                chk($sformatf("%s[%0d] data", tag, i),
                    64'(note_data[tbl[i].data_ch*16 +: 16]), 64'(tbl[i].exp_data));
        end
    endtask

    // Random-phase reference: per channel, the ordered list of expected fetches
    int unsigned m_base [3];
    int unsigned m_len  [3];
    bit          m_loop [3];
    int unsigned m_iss  [3];
    logic [15:0] exp_data [3][64];
    int          exp_cyc  [3][64];
    int          head [3];
    int          tail [3];
    int          last_stb [3];
    int          gap [3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'(16'hC000 + i * 16'h0111);
        rom[4] = 16'h00A1; rom[5] = 16'h00A2; rom[6] = 16'h00A3;
        rst_n = 1'b0; stb = '0; new_addr = '0; new_len = '0; new_loop = 1'b0;
        new_ch = '0; new_vld = 1'b0;
        clr_vcnt();

        // Reset state
        do_reset();
        chk("reset rom_addr", 64'(rom_addr), 64'd0);
        chk("reset note_data", 64'(note_data), 64'd0);
        chk("reset valid", 64'(nvalid), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset overrun", 64'(ovr), 64'd0);

        // Single channel looped pattern, strobes every 5 cycles
        clr_tbl(21);
        set_ld(0, 2'd0, 5'd4, 5'd3, 1'b1);
        for (int k = 0; k < 4; k++) tbl[1 + 5*k].stb = 3'b001;
        set_addr(2, 5'd4); set_addr(7, 5'd5); set_addr(12, 5'd6); set_addr(17, 5'd4);
        set_val(4, 2'd0, 16'h00A1); set_val(9, 2'd0, 16'h00A2);
        set_val(14, 2'd0, 16'h00A3); set_val(19, 2'd0, 16'h00A1);
        run_table("loop");

        // One-shot with address wrap
        do_reset();
        clr_tbl(21);
        set_ld(0, 2'd1, 5'd30, 5'd3, 1'b0);
        for (int k = 0; k < 4; k++) tbl[1 + 5*k].stb = 3'b010;
        set_addr(2, 5'd30); set_addr(7, 5'd31); set_addr(12, 5'd0);
        set_addr(17, 5'd0); set_addr(20, 5'd0);
        set_val(4, 2'd1, rom[30]); set_val(9, 2'd1, rom[31]); set_val(14, 2'd1, rom[0]);
        for (int i = 14; i < 21; i++) tbl[i].exp_done = 3'b010;
        run_table("oneshot");

        // Three-way contention, round robin from channel 0 after reset
        do_reset();
        clr_tbl(11);
        set_ld(0, 2'd0, 5'd0, 5'd4, 1'b1);
        set_ld(1, 2'd1, 5'd8, 5'd4, 1'b1);
        set_ld(2, 2'd2, 5'd16, 5'd4, 1'b1);
        tbl[3].stb = 3'b111;
        set_addr(4, 5'd0); set_addr(5, 5'd8); set_addr(6, 5'd16);
        set_val(6, 2'd0, rom[0]); set_val(7, 2'd1, rom[8]); set_val(8, 2'd2, rom[16]);
        run_table("contend");

        // Load kills the outstanding fetch (load at grant, and one cycle later)
        for (int kd = 1; kd <= 2; kd++) begin
            do_reset();
            load(2'd0, 5'd0, 5'd4, 1'b1);
            clr_vcnt();
            stb = 3'b001; step();
            repeat (kd - 1) step();
            load(2'd0, 5'd10, 5'd4, 1'b1);
            repeat (6) step();
            chk($sformatf("kill%0d no valid", kd), 64'(vcnt[0]), 64'd0);
            stb = 3'b001; step();
            step();
            chk($sformatf("kill%0d new addr", kd), 64'(rom_addr), 64'd10);
            step();
            step();
            chk($sformatf("kill%0d valid", kd), 64'(nvalid), 64'b001);
            chk($sformatf("kill%0d data", kd), 64'(note_data[15:0]), 64'(rom[10]));
        end

        // Reset one cycle after grant
        do_reset();
        load(2'd1, 5'd2, 5'd2, 1'b1);
        clr_vcnt();
        stb = 3'b010; step();
        step();
        chk("rstmid grant addr", 64'(rom_addr), 64'd2);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("rstmid rom_addr", 64'(rom_addr), 64'd0);
        chk("rstmid note_data", 64'(note_data), 64'd0);
        chk("rstmid done", 64'(done), 64'd0);
        chk("rstmid overrun", 64'(ovr), 64'd0);
        repeat (3) step();
        stb = 3'b010; step();
        repeat (6) step();
        stb = 3'b111; step();
        repeat (6) step();
        chk("rstmid no valid", 64'(vcnt[0] + vcnt[1] + vcnt[2]), 64'd0);
        chk("rstmid addr idle", 64'(rom_addr), 64'd0);

        // Double strobe on ch2 while ch0/ch1 contend: merged, overrun flagged
        do_reset();
        load(2'd0, 5'd0, 5'd4, 1'b1);
        load(2'd1, 5'd8, 5'd4, 1'b1);
        load(2'd2, 5'd16, 5'd4, 1'b1);
        clr_vcnt();
        stb = 3'b111; step();
        stb = 3'b100; step();
        repeat (6) step();
        chk("ovr ch0 fetches", 64'(vcnt[0]), 64'd1);
        chk("ovr ch1 fetches", 64'(vcnt[1]), 64'd1);
        chk("ovr ch2 merged", 64'(vcnt[2]), 64'd1);
        chk("ovr ch2 data", 64'(note_data[47:32]), 64'(rom[16]));
        chk("ovr flag", 64'(ovr), 64'(EXP_OVR));
        repeat (4) step();
        chk("ovr sticky", 64'(ovr), 64'(EXP_OVR));
        load(2'd2, 5'd16, 5'd4, 1'b1);
        chk("ovr cleared", 64'(ovr), 64'd0);

        // Randomized rounds against the expected-fetch model
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 3; c++) begin
                m_base[c] = $urandom_range(0, 31);
                m_len[c]  = $urandom_range(1, 8);
                m_loop[c] = 1'($urandom_range(0, 1));
                m_iss[c]  = 0;
                head[c] = 0; tail[c] = 0;
                last_stb[c] = -100; gap[c] = 6;
                load(2'(c), 5'(m_base[c]), 5'(m_len[c]), m_loop[c]);
            end
            for (int cyc = 0; cyc < 310; cyc++) begin
                for (int c = 0; c < 3; c++) begin
                    if (cyc < 300 && (cyc - last_stb[c]) >= gap[c] && $urandom_range(0, 2) == 0) begin
                        stb[c] = 1'b1;
                        last_stb[c] = cyc;
                        gap[c] = $urandom_range(6, 9);
                        if (m_loop[c] || m_iss[c] < m_len[c]) begin
                            int unsigned k, a;
                            k = m_iss[c];
                            a = (m_base[c] + (m_loop[c] ? (k % m_len[c]) : k)) % 32;
                            if (tail[c] < 64) begin
                                exp_data[c][tail[c]] = rom[a];
                                exp_cyc[c][tail[c]]  = cyc;
                                tail[c]++;
                            end
                            m_iss[c]++;
                        end
                    end
                end
                step();
                for (int c = 0; c < 3; c++) begin
                    if (nvalid[c]) begin
                        if (head[c] == tail[c]) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL rand r%0d ch%0d: unexpected valid at cycle %0d", r, c, cyc);
                        end else begin
                            int lat;
                            lat = cyc - exp_cyc[c][head[c]];
                            chk($sformatf("rand r%0d ch%0d data", r, c),
                                64'(note_data[c*16 +: 16]), 64'(exp_data[c][head[c]]));
                            chk($sformatf("rand r%0d ch%0d latency %0d in 3..5", r, c, lat),
                                64'(lat >= 3 && lat <= 5), 64'd1);
                            head[c]++;
                        end
                    end
                end
            end
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("rand r%0d ch%0d missing fetches", r, c), 64'(tail[c] - head[c]), 64'd0);
                chk($sformatf("rand r%0d ch%0d done", r, c), 64'(done[c]),
                    64'(!m_loop[c] && m_iss[c] == m_len[c]));
            end
            chk($sformatf("rand r%0d overrun", r), 64'(ovr), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
